// File: rtl/somador_reg_if.sv
// Operand/result bundle for somador_reg: operands and load enable in,
// combinational and registered sum/carry out.
interface somador_reg_if #(
    parameter int WIDTH = 1
);
    logic             en;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c;
    logic [WIDTH-1:0] saida1;
    logic             saida2;
    logic [WIDTH-1:0] saida1_q;
    logic             saida2_q;
    logic             valid_q;

    // Producer of operands / consumer of results.
    modport master (
        output en, a, b, c,
        input  saida1, saida2, saida1_q, saida2_q, valid_q
    );

    // The adder itself.
    modport slave (
        input  en, a, b, c,
        output saida1, saida2, saida1_q, saida2_q, valid_q
    );
endinterface

// File: rtl/somador_reg.sv
// Ripple-carry full adder (WIDTH-bit operands plus carry-in) with a
// zero-latency combinational result and a registered copy that is loaded
// under en. The registered copy and its valid flag clear asynchronously.

// One 1-bit full-adder cell of the ripple chain.
module somador_fa (
    input  logic a,
    input  logic b,
    input  logic ki,
    output logic s,
    output logic ko
);
    assign s  = a ^ b ^ ki;
    assign ko = (a & b) | (a & ki) | (b & ki);
endmodule

module somador_reg #(
    parameter int WIDTH = 1
) (
    input  logic         clk,
    input  logic         reset,
    somador_reg_if.slave bus
);
    logic [WIDTH-1:0] av;
    logic [WIDTH-1:0] bv;
    logic [WIDTH-1:0] sv;
    logic [WIDTH:0]   k;

    assign av   = bus.a;
    assign bv   = bus.b;
    assign k[0] = bus.c;

    // Carry ripples from bit 0 upward; k[WIDTH] is the carry-out, taken
    // before any truncation of the sum.
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        somador_fa u_fa (
            .a  (av[i]),
            .b  (bv[i]),
            .ki (k[i]),
            .s  (sv[i]),
            .ko (k[i+1])
        );
    end

    assign bus.saida1 = sv;
    assign bus.saida2 = k[WIDTH];

    // Output register: async clear discards any held result; otherwise
    // load the settled combinational result when en is high, else hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.saida1_q <= '0;
            bus.saida2_q <= 1'b0;
            bus.valid_q  <= 1'b0;
        end else if (bus.en) begin
            bus.saida1_q <= sv;
            bus.saida2_q <= k[WIDTH];
            bus.valid_q  <= 1'b1;
        end
    end
endmodule

// File: tb/tb_somador_reg.sv
// Bench for somador_reg: WIDTH=1 and WIDTH=4 instances side by side, an
// arithmetic reference model, directed literal cases and random traffic.
`timescale 1ns/1ps
module tb_somador_reg;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    somador_reg_if #(.WIDTH(1)) i1 ();
    somador_reg_if #(.WIDTH(4)) i4 ();

    somador_reg #(.WIDTH(1)) dut1 (.clk(clk), .reset(reset), .bus(i1));
    somador_reg #(.WIDTH(4)) dut4 (.clk(clk), .reset(reset), .bus(i4));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Plain arithmetic: full (WIDTH+1)-bit sum of the operands and carry-in.
    function automatic logic [32:0] add_ref(input logic [31:0] a, input logic [31:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + 33'(c);
    endfunction

    // Reference for the registered outputs.
    logic       m1_s, m1_c, m1_v;
    logic [3:0] m4_s;
    logic       m4_c, m4_v;
    logic [32:0] r1, r4;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m1_s <= 1'b0; m1_c <= 1'b0; m1_v <= 1'b0;
            m4_s <= 4'h0; m4_c <= 1'b0; m4_v <= 1'b0;
        end else begin
            r1 = add_ref(32'(i1.a), 32'(i1.b), i1.c);
            r4 = add_ref(32'(i4.a), 32'(i4.b), i4.c);
            if (i1.en) begin m1_s <= r1[0]; m1_c <= r1[1]; m1_v <= 1'b1; end
            if (i4.en) begin m4_s <= r4[3:0]; m4_c <= r4[4]; m4_v <= 1'b1; end
        end
    end

    // Every negedge: combinational and registered outputs against the model.
    logic [32:0] e1, e4;
    always @(negedge clk) begin
        e1 = add_ref(32'(i1.a), 32'(i1.b), i1.c);
        e4 = add_ref(32'(i4.a), 32'(i4.b), i4.c);
        chk("w1_sum",   64'(i1.saida1),   64'(e1[0]));
        chk("w1_cout",  64'(i1.saida2),   64'(e1[1]));
        chk("w1_sum_q", 64'(i1.saida1_q), 64'(m1_s));
        chk("w1_cout_q",64'(i1.saida2_q), 64'(m1_c));
        chk("w1_valid", 64'(i1.valid_q),  64'(m1_v));
        chk("w4_sum",   64'(i4.saida1),   64'(e4[3:0]));
        chk("w4_cout",  64'(i4.saida2),   64'(e4[4]));
        chk("w4_sum_q", 64'(i4.saida1_q), 64'(m4_s));
        chk("w4_cout_q",64'(i4.saida2_q), 64'(m4_c));
        chk("w4_valid", 64'(i4.valid_q),  64'(m4_v));
    end

    // Apply inputs 1 time unit after a posedge.
    task automatic drive(input logic e1v, input logic a1, input logic b1, input logic c1,
                         input logic e4v, input logic [3:0] a4, input logic [3:0] b4, input logic c4);
        @(posedge clk);
        #1;
        i1.en = e1v; i1.a = a1; i1.b = b1; i1.c = c1;
        i4.en = e4v; i4.a = a4; i4.b = b4; i4.c = c4;
    endtask

    // {a,b,c,saida1,saida2}
    logic [4:0] tt [8];
    logic [4:0] v;

    initial begin
        checks = 0; failures = 0;
        tt = '{5'b00000, 5'b00110, 5'b01010, 5'b01101,
               5'b10010, 5'b10101, 5'b11001, 5'b11111};
        reset = 1'b0;
        i1.en = 1'b0; i1.a = 1'b0; i1.b = 1'b0; i1.c = 1'b0;
        i4.en = 1'b0; i4.a = 4'h0; i4.b = 4'h0; i4.c = 1'b0;

        // Reset state.
        @(negedge clk);
        chk("rst_valid1", 64'(i1.valid_q), 64'd0);
        chk("rst_valid4", 64'(i4.valid_q), 64'd0);
        chk("rst_sum4_q", 64'(i4.saida1_q), 64'd0);
        #17 reset = 1'b1;

        // WIDTH=1 truth table.
        for (int i = 0; i < 8; i++) begin
            v = tt[i];
            drive(1'b0, v[4], v[3], v[2], 1'b0, 4'h0, 4'h0, 1'b0);
            @(negedge clk);
            chk($sformatf("tt%0d_s", i), 64'(i1.saida1), 64'(v[1]));
            chk($sformatf("tt%0d_c", i), 64'(i1.saida2), 64'(v[0]));
        end

        // Register load, then hold with en=0.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        @(negedge clk);
        chk("ld_sum_q",  64'(i1.saida1_q), 64'd0);
        chk("ld_cout_q", 64'(i1.saida2_q), 64'd1);
        chk("ld_valid",  64'(i1.valid_q),  64'd1);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
        @(negedge clk);
        chk("hold_sum_q",  64'(i1.saida1_q), 64'd0);
        chk("hold_cout_q", 64'(i1.saida2_q), 64'd1);

        // WIDTH=4 boundaries.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 4'h0, 1'b1);
        @(negedge clk);
        chk("wrap_s", 64'(i4.saida1), 64'h0);
        chk("wrap_c", 64'(i4.saida2), 64'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h7, 4'h8, 1'b0);
        @(negedge clk);
        chk("78_s", 64'(i4.saida1), 64'hF);
        chk("78_c", 64'(i4.saida2), 64'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 4'hF, 1'b1);
        @(negedge clk);
        chk("ones_s", 64'(i4.saida1), 64'hF);
        chk("ones_c", 64'(i4.saida2), 64'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h3, 4'h4, 1'b0);
        @(negedge clk);
        chk("ones_s_q",  64'(i4.saida1_q), 64'hF);
        chk("ones_c_q",  64'(i4.saida2_q), 64'd1);
        chk("ones_valid",64'(i4.valid_q),  64'd1);

        // Async reset between edges.
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst_valid4", 64'(i4.valid_q),  64'd0);
        chk("arst_sum4_q", 64'(i4.saida1_q), 64'd0);
        chk("arst_cout4_q",64'(i4.saida2_q), 64'd0);
        chk("arst_valid1", 64'(i1.valid_q),  64'd0);
        chk("arst_comb",   64'(i4.saida1),   64'h7);
        #1 i4.a = 4'h1;
        #1 chk("arst_track", 64'(i4.saida1), 64'h5);
        i1.en = 1'b1; i4.en = 1'b1;
        @(posedge clk);
        #1 chk("arst_en_held", 64'(i4.valid_q), 64'd0);

        // Release with en=1: load on first posedge after release.
        i4.a = 4'h2; i4.b = 4'h3; i4.c = 1'b1;
        #2 reset = 1'b1;
        #1 chk("rel_pre_valid", 64'(i4.valid_q), 64'd0);
        @(posedge clk);
        #1;
        chk("rel_valid", 64'(i4.valid_q),  64'd1);
        chk("rel_sum_q", 64'(i4.saida1_q), 64'h6);
        chk("rel_cout_q",64'(i4.saida2_q), 64'd0);

        // Random traffic with occasional short reset pulses between edges.
        repeat (300) begin
            drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
            if ($urandom_range(0, 29) == 0) begin
                #1 reset = 1'b0;
                #1 reset = 1'b1;
            end
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/somador_reg.md
Name:
somador_reg

Overview:
- Full adder (somador) with WIDTH-bit operands a, b and a 1-bit carry-in c.
- Produces sum (saida1) and carry-out (saida2) combinationally, plus registered copies for pipelined consumers.
- With WIDTH=1 it is the classic 1-bit full adder, driven by the 8-entry truth-table golden model (vector format {a,b,c,saida1,saida2}).
- Leaf arithmetic block in the ADDAC datapath.

Parameters:
- WIDTH, 1, operand/sum bit width; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock for registered outputs.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- en  input  1  load enable for the output registers.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c  input  1  carry-in.
- saida1  output  WIDTH  combinational sum, (a+b+c) mod 2^WIDTH.
- saida2  output  1  combinational carry-out, bit WIDTH of a+b+c.
- saida1_q  output  WIDTH  registered sum.
- saida2_q  output  1  registered carry-out.
- valid_q  output  1  registered outputs hold a valid result.

Behaviour:
- Combinational path:
  - {saida2, saida1} = a + b + c, computed at WIDTH+1 bits. No truncation before the carry is extracted.
  - Implemented as a ripple chain of 1-bit full-adder cells:
    - s_i = a_i ^ b_i ^ k_i
    - k_{i+1} = a_i&b_i | a_i&k_i | b_i&k_i
    - k_0 = c; saida2 = k_WIDTH.
  - Zero latency. No dependence on clk, reset or en.
  - Outputs settle within the same clock phase in which inputs change. The bench applies inputs 1 time unit after posedge and checks at the following negedge.
  - X/Z on any input propagates; no masking.
- Registered path:
  - On posedge clk with en=1: saida1_q<=saida1, saida2_q<=saida2, valid_q<=1.
  - On posedge clk with en=0: saida1_q, saida2_q and valid_q hold their values.
  - Latency is 1 cycle from the sampling edge.
- Reset:
  - When reset=0, saida1_q=0, saida2_q=0 and valid_q=0 immediately, independent of clk.
  - While reset=0, registers stay cleared even if en=1.
  - Release is sampled on the next posedge. The first load occurs on the first posedge where reset=1 and en=1.
  - Reset has no effect on the combinational outputs. saida1/saida2 remain valid during reset.
  - Reset asserted mid-operation discards the held result; valid_q drops asynchronously.
- Boundaries:
  - All-ones operands with c=1 give saida1 = all ones and saida2 = 1.
  - Max wrap (a = all ones, b=0, c=1) gives saida1=0 and saida2=1.
  - Simultaneous input change and clock edge: the register captures the pre-edge settled value.
- WIDTH=1 truth table, a b c -> saida1 saida2:
  - 000->00, 001->10, 010->10, 011->01
  - 100->10, 101->01, 110->01, 111->11

Test Plan:
- WIDTH=1: hold reset=0 for 27 time units, then release. Apply all 8 {a,b,c} combos one per cycle and check at negedge. Required result: exactly the truth table above, e.g. 011 -> saida1=0, saida2=1; 111 -> 1,1. Zero errors over 8 vectors.
- WIDTH=1: set en=1, apply a=1, b=1, c=0. Required: saida1_q=0, saida2_q=1, valid_q=1 after one posedge. Then set en=0 and change inputs to 000: registered outputs hold 0/1.
- WIDTH=4:
  - a=4'hF, b=4'h0, c=1 -> saida1=4'h0, saida2=1.
  - a=4'h7, b=4'h8, c=0 -> saida1=4'hF, saida2=0.
  - a=4'hF, b=4'hF, c=1 -> saida1=4'hF, saida2=1.
- Async reset mid-operation: with valid_q=1, drive reset=0 between clock edges. Required: saida1_q, saida2_q and valid_q go to 0 before the next edge. saida1/saida2 keep tracking the inputs.
- Reset release with en=1: registers stay 0 until the first posedge after reset=1. They load on that edge, and valid_q rises on the same edge.
